tick_gen_multi: RTL

//   Multi-channel programmable tick/clock-enable generator, the parametrised successor to the fixed /5001 divider.

---
 rtl/tick_gen_multi_pkg.sv | 14 +
 rtl/tick_gen_multi_channel.sv | 110 +++++++++++
 rtl/tick_gen_multi.sv | 44 ++++
 3 files changed

// File: rtl/tick_gen_multi_pkg.sv
// Shared encodings and helpers for the multi-channel tick generator.
// Imported by the top level and by the channel module.
package tick_gen_multi_pkg;

   localparam logic MODE_STROBE   = 1'b0;
   localparam logic MODE_SQUARE   = 1'b1;
   localparam int   DEFAULT_DIV_C = 5000;

   // Minimum channel-select width for a given channel count, never below 1.
   function automatic int sel_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/tick_gen_multi_channel.sv
// One divider channel: counter, active/shadow divisor, square-wave toggle and registered outputs.
// A divisor written while running is held in the shadow register until the next wrap.
import tick_gen_multi_pkg::*;

module tick_gen_multi_channel #(
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = DEFAULT_DIV_C
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             mode,
   input  logic             sync_restart,
   input  logic             wr,
   input  logic [CNT_W-1:0] div_data,
   output logic             tick_out,
   output logic             wrap
);

   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [CNT_W-1:0] div_act_r, div_act_s;
   logic [CNT_W-1:0] shadow_r, shadow_s;
   logic             pend_r, pend_s;
   logic             sq_r, sq_s;
   logic             wrap_r, wrap_s;
   logic             tick_r, tick_s;
   logic             hit_s;

   // Next-state: restart beats disable beats normal counting; a write is layered on top.
   always_comb begin
      cnt_s     = cnt_r;
      div_act_s = div_act_r;
      shadow_s  = shadow_r;
      pend_s    = pend_r;
      sq_s      = sq_r;
      wrap_s    = 1'b0;
      tick_s    = 1'b0;
      hit_s     = (cnt_r == div_act_r);

      if (sync_restart) begin
         cnt_s = {CNT_W{1'b0}};
         sq_s  = 1'b0;
         if (pend_r) begin
            div_act_s = shadow_r;
            pend_s    = 1'b0;
         end else begin
            div_act_s = div_act_r;
         end
      end else if (!en) begin
         cnt_s = {CNT_W{1'b0}};
         sq_s  = 1'b0;
      end else if (hit_s) begin
         cnt_s  = {CNT_W{1'b0}};
         wrap_s = 1'b1;
         sq_s   = ~sq_r;
         if (pend_r) begin
            div_act_s = shadow_r;
            pend_s    = 1'b0;
         end else begin
            div_act_s = div_act_r;
         end
      end else begin
         cnt_s = cnt_r + CNT_W'(1);
      end

      // A write landing on the wrap edge goes to the shadow, so this wrap keeps the old divisor.
      if (wr) begin
         if (en) begin
            shadow_s = div_data;
            pend_s   = 1'b1;
         end else begin
            div_act_s = div_data;
            pend_s    = 1'b0;
         end
      end else begin
         shadow_s = shadow_s;
      end

      case (mode)
         MODE_SQUARE: tick_s = sq_s;
         MODE_STROBE: tick_s = wrap_s;
         default:     tick_s = 1'b0;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r     <= {CNT_W{1'b0}};
         div_act_r <= CNT_W'(DEFAULT_DIV);
         shadow_r  <= CNT_W'(DEFAULT_DIV);
         pend_r    <= 1'b0;
         sq_r      <= 1'b0;
         wrap_r    <= 1'b0;
         tick_r    <= 1'b0;
      end else begin
         cnt_r     <= cnt_s;
         div_act_r <= div_act_s;
         shadow_r  <= shadow_s;
         pend_r    <= pend_s;
         sq_r      <= sq_s;
         wrap_r    <= wrap_s;
         tick_r    <= tick_s;
      end
   end

   assign tick_out = tick_r;
   assign wrap     = wrap_r;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick / clock-enable generator.
// Top level only decodes the divisor write address and replicates the channel.
import tick_gen_multi_pkg::*;

module tick_gen_multi #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = DEFAULT_DIV_C,
   parameter int SEL_W       = sel_width(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] en,
   input  logic [NUM_CH-1:0] mode,
   input  logic              sync_restart,
   input  logic              div_wr,
   input  logic [SEL_W-1:0]  div_sel,
   input  logic [CNT_W-1:0]  div_data,
   output logic [NUM_CH-1:0] tick_out,
   output logic [NUM_CH-1:0] wrap
);

   // Selects at or above NUM_CH match no channel, so such writes vanish.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic wr_s;
      assign wr_s = div_wr && (div_sel == SEL_W'(i));

      tick_gen_multi_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk          (clk),
         .reset        (reset),
         .en           (en[i]),
         .mode         (mode[i]),
         .sync_restart (sync_restart),
         .wr           (wr_s),
         .div_data     (div_data),
         .tick_out     (tick_out[i]),
         .wrap         (wrap[i])
      );
   end

endmodule
